// File: rtl/clock_generation_pkg.sv
// Shared types for the transmit-side clock generator: clock domain bundle,
// pin pair, edge events and generator FSM states.
package clock_generation_pkg;

  localparam int RATE_COUNTER_WIDTH = 8;

  typedef struct packed {
    logic clk;
    logic sync_rst;
  } clk_dom_s;

  typedef struct packed {
    logic pos;
    logic neg;
  } recovery_pins_s;

  typedef struct packed {
    logic rising;
    logic falling;
  } generated_events_s;

  typedef enum logic [1:0] {
    GEN_IDLE = 2'd0,
    GEN_HIGH = 2'd1,
    GEN_LOW  = 2'd2
  } gen_state_e;

endpackage

// File: rtl/clock_generation_rate_shadow.sv
// Pending/active rate registers for the generator. New rates wait in a shadow
// and are only promoted at a period boundary so no runt phase is produced.
module generation_rate_shadow
  import clock_generation_pkg::*;
#(
  parameter int RATE_W = RATE_COUNTER_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              update_i,
  input  logic              apply_i,
  input  logic [RATE_W-1:0] high_rate_i,
  input  logic [RATE_W-1:0] low_rate_i,
  output logic [RATE_W-1:0] active_low_o,
  output logic [RATE_W-1:0] eff_high_o,
  output logic [RATE_W-1:0] eff_low_o,
  output logic              pending_o,
  output logic              rate_error_o
);

  logic [RATE_W-1:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic [RATE_W-1:0] act_hi_q, act_hi_d, act_lo_q, act_lo_d;
  logic              pending_q, pending_d;
  logic              rate_error_q, rate_error_d;
  logic              update_ok;

  always_comb begin
    sh_hi_d      = sh_hi_q;
    sh_lo_d      = sh_lo_q;
    act_hi_d     = act_hi_q;
    act_lo_d     = act_lo_q;
    pending_d    = pending_q;
    update_ok    = update_i && (high_rate_i != '0) && (low_rate_i != '0);
    rate_error_d = update_i && !update_ok;
    if (apply_i && pending_q) begin
      act_hi_d  = sh_hi_q;
      act_lo_d  = sh_lo_q;
      pending_d = 1'b0;
    end
    // A strobe coinciding with an apply lands in the shadow for the next boundary
    if (update_ok) begin
      sh_hi_d   = high_rate_i;
      sh_lo_d   = low_rate_i;
      pending_d = 1'b1;
    end
    if (clear_i) begin
      sh_hi_d      = '0;
      sh_lo_d      = '0;
      pending_d    = 1'b0;
      rate_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sh_hi_q      <= '0;
      sh_lo_q      <= '0;
      act_hi_q     <= '0;
      act_lo_q     <= '0;
      pending_q    <= 1'b0;
      rate_error_q <= 1'b0;
    end else begin
      sh_hi_q      <= sh_hi_d;
      sh_lo_q      <= sh_lo_d;
      act_hi_q     <= act_hi_d;
      act_lo_q     <= act_lo_d;
      pending_q    <= pending_d;
      rate_error_q <= rate_error_d;
    end
  end

  assign active_low_o = act_lo_q;
  assign eff_high_o   = pending_q ? sh_hi_q : act_hi_q;
  assign eff_low_o    = pending_q ? sh_lo_q : act_lo_q;
  assign pending_o    = pending_q;
  assign rate_error_o = rate_error_q;

endmodule

// File: rtl/clock_generation.sv
// Synthesizes an IO clock from high/low phase lengths with matching edge events.
//   state    | meaning
//   GEN_IDLE | pins idle, waiting for enable with valid rates
//   GEN_HIGH | pos pin high, counting active high rate
//   GEN_LOW  | pos pin low, counting active low rate (sync may cut it short)
module clock_generation
  import clock_generation_pkg::*;
#(
  parameter int RATE_W = RATE_COUNTER_WIDTH
) (
  input  clk_dom_s          sys_dom_i,
  input  logic              generation_en_i,
  input  logic              clear_state_i,
  input  logic              differential_en_i,
  input  logic [RATE_W-1:0] high_rate_i,
  input  logic [RATE_W-1:0] low_rate_i,
  input  logic              rate_update_i,
  input  logic              sync_en_i,
  input  logic              sync_event_i,
  output recovery_pins_s    io_clk_o,
  output generated_events_s generated_events_o,
  output logic              running_o,
  output logic              rate_pending_o,
  output logic              rate_error_o,
  output logic              sync_missed_o
);

  localparam logic [RATE_W-1:0] RATE_ONE = RATE_W'(1);

  logic clk, rst_n;
  assign clk   = sys_dom_i.clk;
  assign rst_n = sys_dom_i.sync_rst;

  gen_state_e        state_q, state_d;
  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic              pos_q, pos_d, neg_q, neg_d;
  logic              rise_q, rise_d, fall_q, fall_d;
  logic              running_q, running_d;
  logic              sync_missed_q, sync_missed_d;
  logic              apply, sync_hit;
  logic [RATE_W-1:0] active_low, eff_high, eff_low;

  generation_rate_shadow #(.RATE_W(RATE_W)) u_rate_shadow (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_i      (clear_state_i),
    .update_i     (rate_update_i),
    .apply_i      (apply),
    .high_rate_i  (high_rate_i),
    .low_rate_i   (low_rate_i),
    .active_low_o (active_low),
    .eff_high_o   (eff_high),
    .eff_low_o    (eff_low),
    .pending_o    (rate_pending_o),
    .rate_error_o (rate_error_o)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    apply         = 1'b0;
    sync_hit      = sync_en_i && sync_event_i;
    sync_missed_d = 1'b0;
    unique case (state_q)
      GEN_IDLE: begin
        sync_missed_d = sync_hit;
        if (generation_en_i && (eff_high != '0) && (eff_low != '0)) begin
          state_d = GEN_HIGH;
          cnt_d   = eff_high - RATE_ONE;
          apply   = 1'b1;
        end
      end
      GEN_HIGH: begin
        sync_missed_d = sync_hit;
        if (cnt_q == '0) begin
          state_d = GEN_LOW;
          cnt_d   = active_low - RATE_ONE;
        end else begin
          cnt_d = cnt_q - RATE_ONE;
        end
      end
      GEN_LOW: begin
        // Stop request is honoured only where a new HIGH would otherwise begin
        if ((cnt_q == '0) || sync_hit) begin
          if (generation_en_i) begin
            state_d = GEN_HIGH;
            cnt_d   = eff_high - RATE_ONE;
            apply   = 1'b1;
          end else begin
            state_d = GEN_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q - RATE_ONE;
        end
      end
      default: begin
        state_d = GEN_IDLE;
        cnt_d   = '0;
      end
    endcase
    if (clear_state_i) begin
      state_d       = GEN_IDLE;
      cnt_d         = '0;
      apply         = 1'b0;
      sync_missed_d = 1'b0;
    end
    pos_d     = (state_d == GEN_HIGH);
    neg_d     = differential_en_i && !pos_d;
    rise_d    = (state_d == GEN_HIGH) && (state_q != GEN_HIGH);
    fall_d    = (state_d == GEN_LOW) && (state_q == GEN_HIGH);
    running_d = (state_d != GEN_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= GEN_IDLE;
      cnt_q         <= '0;
      pos_q         <= 1'b0;
      neg_q         <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      running_q     <= 1'b0;
      sync_missed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      pos_q         <= pos_d;
      neg_q         <= neg_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      running_q     <= running_d;
      sync_missed_q <= sync_missed_d;
    end
  end

  assign io_clk_o.pos                = pos_q;
  assign io_clk_o.neg                = neg_q;
  assign generated_events_o.rising   = rise_q;
  assign generated_events_o.falling  = fall_q;
  assign running_o                   = running_q;
  assign sync_missed_o               = sync_missed_q;

endmodule

// File: tb/tb_clock_generation.sv
// Bench for clock_generation: directed scenarios then random traffic, all
// checked each cycle against a phase-length model counting elapsed cycles.
module tb_clock_generation;
  import clock_generation_pkg::*;

  localparam int W = RATE_COUNTER_WIDTH;

  logic clk = 1'b0;
  logic rst_n;
  clk_dom_s sys_dom;
  logic en, clr, diff, upd, sen, sev;
  logic [W-1:0] hr, lr;
  recovery_pins_s    io_clk;
  generated_events_s gev;
  logic running, pending, rerr, smiss;

  int n_checks = 0;
  int n_errors = 0;

  // model: phase 0 idle, 1 high, 2 low; elapsed cycles in current phase
  int m_phase, m_elapsed, m_act_hi, m_act_lo, m_sh_hi, m_sh_lo;
  bit m_pend, m_pos, m_neg, m_rise, m_fall, m_run, m_err, m_miss;

  assign sys_dom = {clk, rst_n};
  always #5 clk = ~clk;

  clock_generation dut (
    .sys_dom_i          (sys_dom),
    .generation_en_i    (en),
    .clear_state_i      (clr),
    .differential_en_i  (diff),
    .high_rate_i        (hr),
    .low_rate_i         (lr),
    .rate_update_i      (upd),
    .sync_en_i          (sen),
    .sync_event_i       (sev),
    .io_clk_o           (io_clk),
    .generated_events_o (gev),
    .running_o          (running),
    .rate_pending_o     (pending),
    .rate_error_o       (rerr),
    .sync_missed_o      (smiss)
  );

  task automatic check_val(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  task automatic model_step();
    bit start;
    start  = 0;
    m_rise = 0; m_fall = 0; m_err = 0; m_miss = 0;
    if (!rst_n) begin
      m_phase = 0; m_elapsed = 0; m_act_hi = 0; m_act_lo = 0;
      m_sh_hi = 0; m_sh_lo = 0; m_pend = 0;
      m_pos = 0; m_neg = 0; m_run = 0;
      return;
    end
    if (clr) begin
      m_phase = 0; m_elapsed = 0; m_sh_hi = 0; m_sh_lo = 0; m_pend = 0;
    end else begin
      m_err  = upd && (hr == 0 || lr == 0);
      m_miss = sen && sev && m_phase != 2;
      case (m_phase)
        0: if (en && (m_pend ? (m_sh_hi != 0 && m_sh_lo != 0)
                             : (m_act_hi != 0 && m_act_lo != 0))) start = 1;
        1: begin
          m_elapsed++;
          if (m_elapsed == m_act_hi) begin
            m_phase = 2; m_elapsed = 0; m_fall = 1;
          end
        end
        default: begin
          m_elapsed++;
          if (m_elapsed == m_act_lo || (sen && sev)) begin
            if (en) start = 1;
            else begin m_phase = 0; m_elapsed = 0; end
          end
        end
      endcase
      if (start) begin
        if (m_pend) begin m_act_hi = m_sh_hi; m_act_lo = m_sh_lo; m_pend = 0; end
        m_phase = 1; m_elapsed = 0; m_rise = 1;
      end
      if (upd && hr != 0 && lr != 0) begin
        m_sh_hi = hr; m_sh_lo = lr; m_pend = 1;
      end
    end
    m_pos = (m_phase == 1);
    m_neg = diff && !m_pos;
    m_run = (m_phase != 0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("pos", io_clk.pos, m_pos);
    check_val("neg", io_clk.neg, m_neg);
    check_val("rising", gev.rising, m_rise);
    check_val("falling", gev.falling, m_fall);
    check_val("running", running, m_run);
    check_val("pending", pending, m_pend);
    check_val("rate_error", rerr, m_err);
    check_val("sync_missed", smiss, m_miss);
  endtask

  task automatic quiet();
    clr = 0; upd = 0; sen = 0; sev = 0;
  endtask

  task automatic set_rates(input int h, input int l);
    hr = W'(h); lr = W'(l); upd = 1;
    tick();
    upd = 0;
  endtask

  task automatic wait_event(input bit want_rise, output bit found);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      found = want_rise ? gev.rising : gev.falling;
    end
    check_val(want_rise ? "wait_rising" : "wait_falling", found, 1);
  endtask

  initial begin
    bit found;
    int rises, highs;
    rst_n = 0; en = 0; diff = 0; hr = '0; lr = '0;
    quiet();
    repeat (3) tick();
    check_val("reset_pos", io_clk.pos, 0);
    check_val("reset_pending", pending, 0);
    rst_n = 1;
    diff = 1;

    // 3/2 basic generation, period 5
    set_rates(3, 2);
    en = 1;
    wait_event(1, found);
    rises = 0; highs = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      rises += gev.rising;
      highs += io_clk.pos;
    end
    check_val("rise_count_3_2", rises, 2);
    check_val("high_cycles_3_2", highs, 6);

    // strobe 4/4 mid-HIGH, then a rejected 0/5 strobe
    wait_event(1, found);
    set_rates(4, 4);
    check_val("pending_after_strobe", pending, 1);
    repeat (12) tick();
    set_rates(0, 5);
    repeat (10) tick();

    // graceful stop one cycle into HIGH
    set_rates(3, 2);
    wait_event(1, found);
    wait_event(1, found);
    en = 0;
    repeat (6) tick();
    check_val("stopped_running", running, 0);

    // sync snapping with 2/6
    set_rates(2, 6);
    en = 1;
    wait_event(0, found);
    sen = 1; sev = 1;
    tick();
    sev = 0;
    check_val("sync_rise", gev.rising, 1);
    sev = 1;
    tick();
    sev = 0;
    check_val("sync_missed_high", smiss, 1);
    sen = 0;
    repeat (10) tick();

    // clear and reset mid-HIGH, then 1/1 toggling
    wait_event(1, found);
    clr = 1;
    tick();
    clr = 0;
    check_val("clear_running", running, 0);
    repeat (3) tick();
    set_rates(1, 1);
    repeat (8) tick();
    set_rates(3, 2);
    wait_event(1, found);
    rst_n = 0;
    tick();
    rst_n = 1;
    check_val("reset_mid_high_pos", io_clk.pos, 0);
    set_rates(1, 1);
    repeat (8) tick();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      en   = ($urandom_range(0, 15) != 0);
      clr  = ($urandom_range(0, 99) == 0);
      rst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 49) == 0) diff = ~diff;
      upd  = ($urandom_range(0, 9) == 0);
      hr   = W'($urandom_range(0, 4));
      lr   = W'($urandom_range(0, 5));
      sen  = $urandom_range(0, 1);
      sev  = ($urandom_range(0, 7) == 0);
      tick();
    end
    quiet();
    rst_n = 1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
